// File: rtl/param_move_stack.sv
// Parameterised LIFO of move codes with a non-destructive bottom-to-top dump stream.
// Latency: push/pop/replace visible on top/count one cycle after the capturing edge; first dump beat one cycle after dump_req.
// Backpressure: dump beats hold until dump_ready; push/pop/dump_req are ignored while a dump is in flight.
//
// Ports:
//   clk, rst (async, active-low)   start (enables push/pop/dump_req)   clear (sync flush, always honoured)
//   push/pop/din                   stack operations; push+pop replaces the top entry
//   dump_req, dump_ready           start a readout / accept the current beat
//   top, count, empty, full        stack status (registered)
//   ovf, udf                       sticky push-while-full / pop-while-empty flags
//   busy, dump_valid/data/last     readout in progress and its stream
module param_move_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf,
  output logic             busy,
  output logic             dump_valid,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [0:0]       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] top_q;
  logic             ovf_q;
  logic             udf_q;
  logic [CW-1:0]    ptr_q;
  logic [WIDTH-1:0] dd_q;
  logic             dl_q;

  logic             is_empty;
  logic             is_full;
  logic             idle_op;
  logic             push_req;
  logic             do_push;
  logic             do_repl;
  logic             do_pop;
  logic             ovf_hit;
  logic             udf_hit;
  logic             dump_go;
  logic             xfer;
  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    ptr_p1;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    below_top_idx;
  logic [AW-1:0]    next_ptr_idx;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    // clear wins over every operation, so it gates the whole decode
    idle_op  = (state_q == IDLE) && start && !clear;
    // push+pop on an empty stack degenerates to a plain push
    push_req = idle_op && push && (!pop || is_empty);
    do_push  = push_req && !is_full;
    ovf_hit  = push_req && is_full;
    do_repl  = idle_op && push && pop && !is_empty;
    do_pop   = idle_op && pop && !push && !is_empty;
    udf_hit  = idle_op && pop && !push && is_empty;
    dump_go  = idle_op && dump_req && !push && !pop && !is_empty;
    xfer     = (state_q == DUMP) && dump_ready;

    cnt_m1        = count_q - CW'(1);
    ptr_p1        = ptr_q + CW'(1);
    below_top_idx = AW'(count_q - CW'(2));
    next_ptr_idx  = AW'(ptr_p1);

    wr_en   = do_push || do_repl;
    // a plain push never happens when full, so count_q fits the address width here
    wr_addr = do_push ? AW'(count_q) : AW'(cnt_m1);
  end

  // storage carries no reset; every slot is written before it is read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ptr_q   <= '0;
      dd_q    <= '0;
      dl_q    <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ptr_q   <= '0;
      dd_q    <= '0;
      dl_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (do_push) begin
            count_q <= count_q + CW'(1);
            top_q   <= din;
          end else if (do_repl) begin
            top_q   <= din;
          end else if (do_pop) begin
            count_q <= cnt_m1;
            // the new top is the entry below the current one, or 0 once empty
            top_q   <= (count_q > CW'(1)) ? mem[below_top_idx] : '0;
          end
          if (ovf_hit) ovf_q <= 1'b1;
          if (udf_hit) udf_q <= 1'b1;
          if (dump_go) begin
            state_q <= DUMP;
            ptr_q   <= '0;
            dd_q    <= mem[AW'(0)];
            dl_q    <= (count_q == CW'(1));
          end
        end
        DUMP: begin
          if (xfer) begin
            if (dl_q) begin
              state_q <= IDLE;
              ptr_q   <= '0;
              dd_q    <= '0;
              dl_q    <= 1'b0;
            end else begin
              ptr_q <= ptr_p1;
              dd_q  <= mem[next_ptr_idx];
              dl_q  <= (ptr_p1 == cnt_m1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign top        = top_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign ovf        = ovf_q;
  assign udf        = udf_q;
  assign busy       = (state_q == DUMP);
  assign dump_valid = (state_q == DUMP);
  assign dump_data  = dd_q;
  assign dump_last  = dl_q;

endmodule

// File: tb/tb_param_move_stack.sv
// Directed bench for param_move_stack (WIDTH=2, DEPTH=4).
// Stimulus queues expected status snapshots and dump beats; a negedge monitor pops and compares.
// Dump beats are compared every cycle dump_valid is high and retired only on dump_ready.
module tb_param_move_stack;

  localparam int W  = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          push;
  logic          pop;
  logic [W-1:0]  din;
  logic          clear;
  logic          dump_req;
  logic          dump_ready;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;
  logic          busy;
  logic          dump_valid;
  logic [W-1:0]  dump_data;
  logic          dump_last;

  param_move_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop), .din(din),
    .clear(clear), .dump_req(dump_req), .dump_ready(dump_ready),
    .top(top), .count(count), .empty(empty), .full(full), .ovf(ovf), .udf(udf),
    .busy(busy), .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [W-1:0]  tp;
    logic          emp;
    logic          ful;
    logic          ov;
    logic          ud;
    logic          bsy;
    logic          dv;
  } stat_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  stat_t sq[$];
  int    sid[$];
  beat_t bq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  // monitor: one status snapshot per queued entry, dump beats whenever valid
  always @(negedge clk) begin
    stat_t e;
    beat_t b;
    int    id;
    if (rst === 1'b1) begin
      if (sq.size() > 0) begin
        e  = sq.pop_front();
        id = sid.pop_front();
        chk("count",      id, 32'(count),      32'(e.cnt));
        chk("top",        id, 32'(top),        32'(e.tp));
        chk("empty",      id, 32'(empty),      32'(e.emp));
        chk("full",       id, 32'(full),       32'(e.ful));
        chk("ovf",        id, 32'(ovf),        32'(e.ov));
        chk("udf",        id, 32'(udf),        32'(e.ud));
        chk("busy",       id, 32'(busy),       32'(e.bsy));
        chk("dump_valid", id, 32'(dump_valid), 32'(e.dv));
      end
      if (dump_valid === 1'b1) begin
        if (bq.size() == 0) begin
          chk("dump_unexpected", 0, 32'(1), 32'(0));
        end else begin
          b = bq[0];
          chk("dump_data", bq.size(), 32'(dump_data), 32'(b.d));
          chk("dump_last", bq.size(), 32'(dump_last), 32'(b.l));
          if (dump_ready === 1'b1) void'(bq.pop_front());
        end
      end else begin
        chk("dump_data_idle", 0, 32'(dump_data), 32'(0));
        chk("dump_last_idle", 0, 32'(dump_last), 32'(0));
      end
    end
  end

  task automatic idle_in();
    push = 1'b0; pop = 1'b0; clear = 1'b0; dump_req = 1'b0; din = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic p, input logic q, input logic [W-1:0] d,
                    input logic cl, input logic dr);
    push = p; pop = q; din = d; clear = cl; dump_req = dr;
    cyc();
    idle_in();
  endtask

  task automatic expst(input int id, input int c, input int t, input logic e, input logic f,
                       input logic o, input logic u, input logic b, input logic v);
    stat_t s;
    s.cnt = CW'(c); s.tp = W'(t); s.emp = e; s.ful = f;
    s.ov = o; s.ud = u; s.bsy = b; s.dv = v;
    sq.push_back(s);
    sid.push_back(id);
  endtask

  task automatic bexp(input int d, input logic l);
    beat_t b;
    b.d = W'(d); b.l = l;
    bq.push_back(b);
  endtask

  task automatic check_reset(input int id);
    chk("rst_count",      id, 32'(count),      32'(0));
    chk("rst_top",        id, 32'(top),        32'(0));
    chk("rst_empty",      id, 32'(empty),      32'(1));
    chk("rst_full",       id, 32'(full),       32'(0));
    chk("rst_ovf",        id, 32'(ovf),        32'(0));
    chk("rst_udf",        id, 32'(udf),        32'(0));
    chk("rst_busy",       id, 32'(busy),       32'(0));
    chk("rst_dump_valid", id, 32'(dump_valid), 32'(0));
    chk("rst_dump_data",  id, 32'(dump_data),  32'(0));
    chk("rst_dump_last",  id, 32'(dump_last),  32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; dump_ready = 1'b0;
    idle_in();
    #3;
    check_reset(0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;

    // fill to full, then overflow
    op(1, 0, 1, 0, 0); expst(1, 1, 1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0); expst(2, 2, 2, 0, 0, 0, 0, 0, 0);
    op(1, 0, 3, 0, 0); expst(3, 3, 3, 0, 0, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0); expst(4, 4, 0, 0, 1, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0); expst(5, 4, 0, 0, 1, 1, 0, 0, 0);

    // drain, then underflow, then clear the flags
    op(0, 1, 0, 0, 0); expst(6, 3, 3, 0, 0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0); expst(7, 2, 2, 0, 0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0); expst(8, 1, 1, 0, 0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0); expst(9, 0, 0, 1, 0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0); expst(10, 0, 0, 1, 0, 1, 1, 0, 0);
    op(0, 0, 0, 1, 0); expst(11, 0, 0, 1, 0, 0, 0, 0, 0);

    // replace top, and push+pop on empty behaving as push
    op(1, 0, 1, 0, 0); expst(12, 1, 1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0); expst(13, 2, 2, 0, 0, 0, 0, 0, 0);
    op(1, 1, 3, 0, 0); expst(14, 2, 3, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0); expst(15, 0, 0, 1, 0, 0, 0, 0, 0);
    op(1, 1, 1, 0, 0); expst(16, 1, 1, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0); expst(17, 0, 0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1); expst(18, 0, 0, 1, 0, 0, 0, 0, 0);

    // dump {1,2,3} with ready pattern 1,0,1,1
    op(1, 0, 1, 0, 0); expst(19, 1, 1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0); expst(20, 2, 2, 0, 0, 0, 0, 0, 0);
    op(1, 0, 3, 0, 0); expst(21, 3, 3, 0, 0, 0, 0, 0, 0);
    bexp(1, 0); bexp(2, 0); bexp(3, 1);
    dump_ready = 1'b1;
    op(0, 0, 0, 0, 1); expst(22, 3, 3, 0, 0, 0, 0, 1, 1);
    cyc(); dump_ready = 1'b0; expst(23, 3, 3, 0, 0, 0, 0, 1, 1);
    cyc(); dump_ready = 1'b1; expst(24, 3, 3, 0, 0, 0, 0, 1, 1);
    cyc();                    expst(25, 3, 3, 0, 0, 0, 0, 1, 1);
    cyc(); dump_ready = 1'b0; expst(26, 3, 3, 0, 0, 0, 0, 0, 0);

    // ops ignored during dump, then clear aborts it
    bexp(1, 0);
    op(0, 0, 0, 0, 1); expst(27, 3, 3, 0, 0, 0, 0, 1, 1);
    op(1, 1, 2, 0, 0); expst(28, 3, 3, 0, 0, 0, 0, 1, 1);
    op(0, 0, 0, 1, 0); bq.delete(); expst(29, 0, 0, 1, 0, 0, 0, 0, 0);

    // asynchronous reset mid-dump, then first edge after release accepts a push
    op(1, 0, 1, 0, 0); expst(30, 1, 1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 2, 0, 0); expst(31, 2, 2, 0, 0, 0, 0, 0, 0);
    bexp(1, 0);
    op(0, 0, 0, 0, 1); expst(32, 2, 2, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset(99);
    bq.delete();
    @(negedge clk);
    rst = 1'b1;
    op(1, 0, 3, 0, 0); expst(33, 1, 3, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("status_queue_drained", 100, 32'(sq.size()), 32'(0));
    chk("beat_queue_drained",   100, 32'(bq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_move_stack.md
PARAM_MOVE_STACK -- requirements
Module: param_move_stack

Interface
REQ-001 Parameter WIDTH, default 2, bit width of one stored entry (a move code).
REQ-002 Parameter DEPTH, default 256, maximum number of entries; legal range 2..65536.
REQ-003 Derived localparam CW = $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low; the block is in reset while rst=0.
REQ-006 start  in  1  operation enable; push, pop and dump_req are ignored while 0.
REQ-007 push  in  1  push din onto the stack.
REQ-008 pop  in  1  remove the top entry.
REQ-009 din  in  WIDTH  entry to push.
REQ-010 clear  in  1  synchronous flush, honoured regardless of start.
REQ-011 dump_req  in  1  request a non-destructive bottom-to-top readout.
REQ-012 dump_ready  in  1  consumer accepts dump_data this cycle.
REQ-013 top  out  WIDTH  current top entry; 0 when empty.
REQ-014 count  out  CW  number of stored entries.
REQ-015 empty  out  1  count==0.
REQ-016 full  out  1  count==DEPTH.
REQ-017 ovf  out  1  sticky: push attempted while full.
REQ-018 udf  out  1  sticky: pop attempted while empty.
REQ-019 busy  out  1  dump in progress.
REQ-020 dump_valid / dump_data[WIDTH] / dump_last  out  readout stream; dump_last marks the top entry.

Function
REQ-021 FSM states IDLE and DUMP; busy=1 exactly in DUMP.
REQ-022 All outputs are registered or decoded from registers; top, count, empty, full reflect an operation from the cycle after the capturing edge.
REQ-023 IDLE, start=1, push only, not full: mem[count]<=din, count+1.
REQ-024 IDLE, start=1, pop only, not empty: count-1; popped slot contents are don't-care.
REQ-025 IDLE, start=1, push and pop together, not empty: top entry replaced by din, count unchanged.
REQ-026 Push and pop together while empty: treated as push only; udf not set.
REQ-027 Push while full (without pop): entry discarded, count unchanged, ovf<=1.
REQ-028 Pop while empty (without push): count unchanged, udf<=1.
REQ-029 clear=1: count<=0, ovf<=0, udf<=0, state<=IDLE, dump outputs deasserted next cycle; clear has priority over every other input in both states.
REQ-030 IDLE, start=1, dump_req=1, no push/pop, count>0: enter DUMP with read pointer 0; dump_req while push or pop asserted is ignored.
REQ-031 dump_req with count==0: ignored, stay IDLE, no flag set.
REQ-032 DUMP: dump_valid=1, dump_data=mem[ptr], dump_last=(ptr==count-1); dump_valid, dump_data, dump_last hold stable until dump_valid&dump_ready.
REQ-033 DUMP transfer (dump_valid&dump_ready): ptr+1; on the dump_last transfer return to IDLE, dump_valid=0 next cycle.
REQ-034 In DUMP, push, pop and dump_req are ignored without setting ovf/udf; stored contents and count unchanged by the dump.
REQ-035 dump_data and dump_last are 0 whenever dump_valid=0.
REQ-036 No combinational path from any input to any output.

Reset
REQ-037 While rst=0: state IDLE, count=0, empty=1, full=0, top=0, ovf=0, udf=0, busy=0, dump_valid=0, dump_data=0, dump_last=0.
REQ-038 Reset asserted mid-DUMP or mid-operation aborts it immediately; storage array need not be reset.
REQ-039 First operation is accepted on the first rising edge after rst returns to 1.

Verification (WIDTH=2, DEPTH=4)
REQ-040 Push 1,2,3,0 -> count 1,2,3,4, full=1 after 4th, top=0; 5th push of 2 -> ovf=1, count=4, top=0.
REQ-041 From 4 entries, pop x4 then pop once more -> count 3,2,1,0, empty=1, top=0, udf=1; clear -> ovf=udf=0.
REQ-042 Stack {1,2}, push+pop with din=3 -> count=2, top=3; on empty stack push+pop din=1 -> count=1, top=1, udf=0.
REQ-043 Stack {1,2,3}, dump_req, dump_ready pattern 1,0,1,1 -> data 1,2,2(held),3, dump_last only with 3, busy cleared after, count=3, top=3.
REQ-044 During DUMP assert push din=2 and pop -> ignored, no flags; assert clear mid-dump -> busy=0, dump_valid=0, count=0 next cycle.
REQ-045 Drop rst to 0 between clock edges during DUMP -> all outputs at REQ-037 values without waiting for clk.
